// File: rtl/vc_flit_tx.sv
// vc_flit_tx: wormhole round-robin VC drain onto one registered flit link.
// Optional packet counter output pkt_cnt_o enabled by VC_TX_PKT_CNT_EN.
module vc_flit_tx #(
  parameter int NUM_VC      = 4,
  parameter int VC_ID_WIDTH = 2,
  parameter int FLIT_WIDTH  = 34
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_VC*FLIT_WIDTH-1:0] fdata_i,
  input  logic [NUM_VC-1:0]            valid_i,
  output logic [NUM_VC-1:0]            ready_o,
  output logic [FLIT_WIDTH-1:0]        fdata_o,
  output logic                         valid_o,
  output logic [VC_ID_WIDTH-1:0]       vc_id_o,
  input  logic                         ready_i,
`ifdef VC_TX_PKT_CNT_EN
  output logic [15:0]                  pkt_cnt_o,
`endif
  output logic                         err_o
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b11;

  state_t                  state_q, state_d;
  logic [VC_ID_WIDTH-1:0]  lock_vc_q, lock_vc_d;
  logic [VC_ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [FLIT_WIDTH-1:0]   fdata_q, fdata_d;
  logic [VC_ID_WIDTH-1:0]  vc_id_q, vc_id_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    load_en;
  logic                    gnt_any;
  logic [VC_ID_WIDTH-1:0]  gnt_idx;
  logic [VC_ID_WIDTH-1:0]  cand;
  logic                    xfer;
  logic [FLIT_WIDTH-1:0]   g_flit;
  logic [1:0]              g_type;
  logic [7:0]              g_len;

  assign load_en = !valid_q || ready_i;

  // Grant: locked VC wins outright, else round-robin after rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == LOCKED) begin
      gnt_any = 1'b1;
      gnt_idx = lock_vc_q;
    end else begin
      for (int i = 1; i <= NUM_VC; i++) begin
        cand = rr_ptr_q + VC_ID_WIDTH'(i);
        if (!gnt_any && valid_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // Pop strobe and decode of the granted flit.
  always_comb begin
    ready_o = '0;
    if (gnt_any && load_en) ready_o[gnt_idx] = 1'b1;
    xfer   = gnt_any && load_en && valid_i[gnt_idx];
    g_flit = fdata_i[gnt_idx*FLIT_WIDTH +: FLIT_WIDTH];
    g_type = g_flit[33:32];
    g_len  = g_flit[29:22];
  end

  // Next state: packet lock, round-robin pointer, output register.
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    fdata_d   = fdata_q;
    vc_id_d   = vc_id_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    if (load_en) valid_d = xfer;
    if (xfer) begin
      fdata_d = g_flit;
      vc_id_d = gnt_idx;
      unique case (state_q)
        IDLE: begin
          rr_ptr_d = gnt_idx;
          if (g_type == T_HEAD) begin
            if (g_len != 8'd0) begin
              state_d   = LOCKED;
              lock_vc_d = gnt_idx;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        LOCKED: begin
          if (g_type == T_HEAD) err_d = 1'b1;
          else if (g_type == T_TAIL) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset drops the lock and any in-flight flit.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= IDLE;
      lock_vc_q <= '0;
      rr_ptr_q  <= VC_ID_WIDTH'(NUM_VC - 1);
      fdata_q   <= '0;
      vc_id_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
      fdata_q   <= fdata_d;
      vc_id_q   <= vc_id_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign fdata_o = fdata_q;
  assign vc_id_o = vc_id_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

`ifdef VC_TX_PKT_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        pkt_done;

  // A packet completes when its tail or single-flit head leaves downstream.
  always_comb begin
    pkt_done  = valid_q && ready_i &&
                ((fdata_q[33:32] == T_TAIL) ||
                 ((fdata_q[33:32] == T_HEAD) && (fdata_q[29:22] == 8'd0)));
    pkt_cnt_d = pkt_done ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
  end

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) pkt_cnt_q <= '0;
    else       pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_vc_flit_tx.sv
// tb_vc_flit_tx: directed stimulus, scoreboard queue, decoupled monitor.
// Per-VC source queues emulate the upstream VC buffers.
module tb_vc_flit_tx;

  localparam int NV = 4;
  localparam int W  = 34;

  logic            clk = 1'b0;
  logic            arst;
  logic [NV*W-1:0] fdata_i;
  logic [NV-1:0]   valid_i;
  logic [NV-1:0]   ready_o;
  logic [W-1:0]    fdata_o;
  logic            valid_o;
  logic [1:0]      vc_id_o;
  logic            ready_i;
  logic            err_o;
`ifdef VC_TX_PKT_CNT_EN
  logic [15:0]     pkt_cnt_o;
`endif

  vc_flit_tx dut (
    .clk     (clk),
    .arst    (arst),
    .fdata_i (fdata_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .fdata_o (fdata_o),
    .valid_o (valid_o),
    .vc_id_o (vc_id_o),
    .ready_i (ready_i),
`ifdef VC_TX_PKT_CNT_EN
    .pkt_cnt_o (pkt_cnt_o),
`endif
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   vc;
    logic [W-1:0] f;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] src_q[NV][$];
  int           pass_cnt = 0;
  int           tot_cnt  = 0;
  int           pkt_model = 0;
  bit           chk_lock = 1'b0;

  function automatic logic [W-1:0] hd(input logic [7:0] len,
                                      input logic [21:0] p);
    return {2'b00, 2'b00, len, p};
  endfunction

  function automatic logic [W-1:0] bd(input logic [31:0] p);
    return {2'b01, p};
  endfunction

  function automatic logic [W-1:0] tl(input logic [31:0] p);
    return {2'b11, p};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic send(input int v, input logic [W-1:0] f,
                      input bit e, input bit expect_it);
    exp_t x;
    src_q[v].push_back(f);
    if (expect_it) begin
      x.vc = 2'(v);
      x.f = f;
      x.err = e;
      exp_q.push_back(x);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #2;
      done = (exp_q.size() == 0) && (src_q[0].size() == 0) &&
             (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
             (src_q[3].size() == 0);
    end
    if (!done) begin
      tot_cnt++;
      $display("FAIL drain_timeout: pending %0d expected flits", exp_q.size());
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = valid_o;
    end
    if (!ok) begin
      tot_cnt++;
      $display("FAIL wait_valid_timeout: valid_o %b required 1", valid_o);
    end
  endtask

  // Upstream buffer model: pop on accepted handshakes, present queue heads.
  initial begin
    logic [NV-1:0] fire;
    valid_i = '0;
    fdata_i = '0;
    forever begin
      @(negedge clk);
      fire = arst ? (valid_i & ready_o) : '0;
      if (chk_lock && src_q[2].size() > 0)
        chk("lock_ready0", 64'(ready_o[0]), 64'd0);
      @(posedge clk); #1;
      for (int v = 0; v < NV; v++) begin
        if (!arst) src_q[v].delete();
        else if (fire[v]) void'(src_q[v].pop_front());
        valid_i[v] = src_q[v].size() > 0;
        fdata_i[v*W +: W] = (src_q[v].size() > 0) ? src_q[v][0] : '0;
      end
    end
  end

  // Monitor: compare every accepted output flit against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!arst) begin
        pkt_model = 0;
      end else if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_flit: vc %0d data %h, none required",
                   vc_id_o, fdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("fdata", 64'(fdata_o), 64'(e.f));
          chk("vc_id", 64'(vc_id_o), 64'(e.vc));
          chk("err", 64'(err_o), 64'(e.err));
          if (e.f[33:32] == 2'b11 ||
              (e.f[33:32] == 2'b00 && e.f[29:22] == 8'd0))
            pkt_model++;
        end
      end
    end
  end

  initial begin
    bit ok;
    int n;
    arst = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 arst = 1'b1;

    repeat (10) begin
      @(negedge clk);
      chk("reset_idle", 64'({valid_o, ready_o, err_o, fdata_o}), 64'd0);
    end
`ifdef VC_TX_PKT_CNT_EN
    chk("pkt_cnt_reset", 64'(pkt_cnt_o), 64'd0);
`endif

    // Single-flit heads on all VCs: round-robin 0,1,2,3,0,1.
    @(posedge clk); #2;
    send(0, hd(8'd0, 22'h00A0), 1'b0, 1'b0);
    send(0, hd(8'd0, 22'h00A1), 1'b0, 1'b0);
    send(1, hd(8'd0, 22'h01A0), 1'b0, 1'b0);
    send(1, hd(8'd0, 22'h01A1), 1'b0, 1'b0);
    send(2, hd(8'd0, 22'h02A0), 1'b0, 1'b0);
    send(3, hd(8'd0, 22'h03A0), 1'b0, 1'b0);
    exp_q.push_back('{vc: 2'd0, f: hd(8'd0, 22'h00A0), err: 1'b0});
    exp_q.push_back('{vc: 2'd1, f: hd(8'd0, 22'h01A0), err: 1'b0});
    exp_q.push_back('{vc: 2'd2, f: hd(8'd0, 22'h02A0), err: 1'b0});
    exp_q.push_back('{vc: 2'd3, f: hd(8'd0, 22'h03A0), err: 1'b0});
    exp_q.push_back('{vc: 2'd0, f: hd(8'd0, 22'h00A1), err: 1'b0});
    exp_q.push_back('{vc: 2'd1, f: hd(8'd0, 22'h01A1), err: 1'b0});
    wait_valid(ok);
    if (ok) begin
      chk("b2b_valid", 64'(valid_o), 64'd1);
      repeat (5) begin
        @(negedge clk);
        chk("b2b_valid", 64'(valid_o), 64'd1);
      end
    end
    drain();

    // VC2 packet locks out VC0 until its tail is transferred.
    send(2, hd(8'd2, 22'h020B0), 1'b0, 1'b1);
    send(2, bd(32'h0002_00B1), 1'b0, 1'b1);
    send(2, tl(32'h0002_00B2), 1'b0, 1'b1);
    for (int c = 0; c < 20 && src_q[2].size() == 3; c++) begin
      @(posedge clk); #2;
    end
    send(0, hd(8'd0, 22'h000B0), 1'b0, 1'b1);
    chk_lock = 1'b1;
    drain();
    chk_lock = 1'b0;

    // Downstream stall mid-packet on VC1.
    send(1, hd(8'd3, 22'h010C0), 1'b0, 1'b1);
    send(1, bd(32'h0001_00C1), 1'b0, 1'b1);
    send(1, bd(32'h0001_00C2), 1'b0, 1'b1);
    send(1, tl(32'h0001_00C3), 1'b0, 1'b1);
    for (int c = 0; c < 20 && src_q[1].size() > 2; c++) begin
      @(posedge clk); #2;
    end
    ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", 64'(ready_o), 64'd0);
      chk("stall_valid", 64'(valid_o), 64'd1);
      chk("stall_fdata", 64'(fdata_o), 64'(bd(32'h0001_00C1)));
      chk("stall_vc", 64'(vc_id_o), 64'd1);
      @(posedge clk); #2;
    end
    ready_i = 1'b1;
    drain();

    // Body flit while idle: forwarded with a single error pulse.
    send(3, bd(32'h0003_00D0), 1'b1, 1'b1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (err_o) n++;
    end
    chk("err_idle_pulses", 64'(n), 64'd1);
    drain();

    // Head on the locked VC while locked: one error pulse.
    send(0, hd(8'd1, 22'h000E0), 1'b0, 1'b1);
    send(0, hd(8'd1, 22'h000E1), 1'b1, 1'b1);
    send(0, tl(32'h0000_00E2), 1'b0, 1'b1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (err_o) n++;
    end
    chk("err_lock_pulses", 64'(n), 64'd1);
    drain();
`ifdef VC_TX_PKT_CNT_EN
    @(posedge clk); #2;
    chk("pkt_cnt", 64'(pkt_cnt_o), 64'(pkt_model));
`endif

    // Reset while locked on VC1 with a flit held on the output.
    ready_i = 1'b0;
    send(1, hd(8'd2, 22'h010F0), 1'b0, 1'b0);
    send(1, bd(32'h0001_00F1), 1'b0, 1'b0);
    wait_valid(ok);
    @(posedge clk); #2;
    arst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_regs", 64'({vc_id_o, err_o, fdata_o}), 64'd0);
    repeat (2) @(posedge clk);
    #2 arst = 1'b1;
    ready_i = 1'b1;
`ifdef VC_TX_PKT_CNT_EN
    chk("pkt_cnt_rst", 64'(pkt_cnt_o), 64'd0);
`endif
    send(2, hd(8'd0, 22'h020F8), 1'b0, 1'b1);
    drain();
`ifdef VC_TX_PKT_CNT_EN
    @(posedge clk); #2;
    chk("pkt_cnt_after_rst", 64'(pkt_cnt_o), 64'(pkt_model));
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
